// File: rtl/alu_add_hold_if.sv
// alu_add_hold_if: operand/request and result/flag signals between a requester and the ALU hold stage
interface alu_add_hold_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             carry_in;
   logic             decimal_en;
   logic [2:0]       op;
   logic             start;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             ac_load;
   logic             c_out;
   logic             v_out;
   logic             z_out;
   logic             n_out;

   modport master (
      output a_in, b_in, carry_in, decimal_en, op, start,
      input  busy, result, ac_load, c_out, v_out, z_out, n_out
   );

   modport slave (
      input  a_in, b_in, carry_in, decimal_en, op, start,
      output busy, result, ac_load, c_out, v_out, z_out, n_out
   );
endinterface

// File: rtl/alu_add_hold.sv
// alu_add_hold: 8-bit ALU with ADD hold register, optional BCD correction cycle and accumulator load pulse
module alu_add_hold #(parameter int WIDTH = 8) (
   input  logic             clk,
   input  logic             rst,
   alu_add_hold_if.slave    io,
   input  logic             bus_enable,
   inout  tri [WIDTH-1:0]   data_out
);
   typedef enum logic [1:0] {IDLE, ADJUST, DONE} state_t;
   state_t           state;
   logic             sbc, arith, lo_borrow, c_next, v_next, adj_c, adj_c_q;
   logic [WIDTH-1:0] b_eff, bin_res, adj, adj_q;
   logic [WIDTH:0]   sum;
   logic [4:0]       lo_add, hi_add;

   assign sbc       = io.op == 3'd1;
   assign arith     = io.op[2:1] == 2'b00;
   assign b_eff     = sbc ? ~io.b_in : io.b_in;
   assign sum       = {1'b0, io.a_in} + {1'b0, b_eff} + (WIDTH+1)'(io.carry_in);
   assign lo_add    = {1'b0, io.a_in[3:0]} + {1'b0, io.b_in[3:0]} + 5'(io.carry_in);
   assign hi_add    = {1'b0, io.a_in[7:4]} + {1'b0, io.b_in[7:4]} + 5'(lo_add > 5'd9);
   assign lo_borrow = {1'b0, io.a_in[3:0]} < {1'b0, io.b_in[3:0]} + 5'(!io.carry_in);
   // Decimal correction is folded into one signed delta at capture so ADJUST needs no operands
   assign adj   = sbc ? WIDTH'(0) - (lo_borrow ? WIDTH'(6) : WIDTH'(0)) - (sum[WIDTH] ? WIDTH'(0) : WIDTH'(8'h60))
                      : (lo_add > 5'd9 ? WIDTH'(6) : WIDTH'(0)) + (hi_add > 5'd9 ? WIDTH'(8'h60) : WIDTH'(0));
   assign adj_c  = sbc ? sum[WIDTH] : hi_add > 5'd9;
   assign c_next = arith ? sum[WIDTH] : (io.op == 3'd5 || io.op == 3'd6) ? io.a_in[0] : io.c_out;
   assign v_next = arith ? (io.a_in[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != io.a_in[WIDTH-1]) : io.v_out;

   always_comb begin
      bin_res = io.a_in;
      case (io.op)
         3'd0, 3'd1: bin_res = sum[WIDTH-1:0];
         3'd2:       bin_res = io.a_in & io.b_in;
         3'd3:       bin_res = io.a_in | io.b_in;
         3'd4:       bin_res = io.a_in ^ io.b_in;
         3'd5:       bin_res = {1'b0, io.a_in[WIDTH-1:1]};
         3'd6:       bin_res = {io.carry_in, io.a_in[WIDTH-1:1]};
         default:    bin_res = io.a_in;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         io.result  <= '0;
         io.c_out   <= 1'b0;
         io.v_out   <= 1'b0;
         io.z_out   <= 1'b0;
         io.n_out   <= 1'b0;
         io.busy    <= 1'b0;
         io.ac_load <= 1'b0;
         adj_q      <= '0;
         adj_c_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (io.start) begin
               io.result <= bin_res;
               io.c_out  <= c_next;
               io.v_out  <= v_next;
               io.z_out  <= bin_res == '0;
               io.n_out  <= bin_res[WIDTH-1];
               adj_q     <= adj;
               adj_c_q   <= adj_c;
               if (arith && io.decimal_en) begin
                  state   <= ADJUST;
                  io.busy <= 1'b1;
               end else begin
                  state      <= DONE;
                  io.ac_load <= 1'b1;
               end
            end
            ADJUST: begin
               io.result  <= io.result + adj_q;
               io.c_out   <= adj_c_q;
               io.busy    <= 1'b0;
               io.ac_load <= 1'b1;
               state      <= DONE;
            end
            default: begin
               io.ac_load <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign data_out = bus_enable ? io.result : 'z;
endmodule

// File: tb/tb_alu_add_hold.sv
// tb_alu_add_hold: random and directed stimulus checked against a behavioural model of alu_add_hold
module tb_alu_add_hold;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bus_enable = 1'b0;
   tri [7:0] data_bus;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_add_hold_if io ();
   alu_add_hold dut (.clk(clk), .rst(rst), .io(io), .bus_enable(bus_enable), .data_out(data_bus));

   genvar i;
   generate
      for (i = 0; i < 8; i++) begin : g_pu
         pullup (data_bus[i]);
      end
   endgenerate

   logic [7:0] m_res = 8'h00;
   logic [7:0] m_pend_res = 8'h00;
   logic m_c = 0, m_v = 0, m_z = 0, m_n = 0, m_busy = 0, m_load = 0, m_pend_c = 0;
   int m_lat = 0;

   function automatic void model_op(input int a, input int b, input int cin, input int op,
                                    input bit c0, input bit v0, output int res, output bit c,
                                    output bit v, output int dres, output bit dc);
      int bx, s, lo, hi;
      c = c0; v = v0; dres = 0; dc = 0; res = a;
      case (op)
         0, 1: begin
            bx  = (op == 1) ? (~b & 255) : b;
            s   = a + bx + cin;
            res = s & 255;
            c   = s > 255;
            v   = ((a >> 7) == (bx >> 7)) && (((res >> 7) & 1) != (a >> 7));
            if (op == 0) begin
               lo   = (a & 15) + (b & 15) + cin;
               hi   = (a >> 4) + (b >> 4) + ((lo > 9) ? 1 : 0);
               dres = (res + ((lo > 9) ? 6 : 0) + ((hi > 9) ? 96 : 0)) & 255;
               dc   = hi > 9;
            end else begin
               lo   = (a & 15) - (b & 15) - (1 - cin);
               dres = (res - ((lo < 0) ? 6 : 0) - (c ? 0 : 96)) & 255;
               dc   = c;
            end
         end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: begin res = a >> 1; c = a & 1; end
         6: begin res = (a >> 1) | (cin << 7); c = a & 1; end
         default: res = a;
      endcase
   endfunction

   always @(posedge clk) begin : model
      int r, dr;
      bit c, v, dc;
      if (rst) begin
         m_res = 0; m_c = 0; m_v = 0; m_z = 0; m_n = 0; m_busy = 0; m_load = 0; m_lat = 0;
      end else if (m_lat == 0) begin
         m_load = 0;
         m_busy = 0;
         if (io.start) begin
            model_op(int'(io.a_in), int'(io.b_in), int'(io.carry_in), int'(io.op), m_c, m_v, r, c, v, dr, dc);
            m_res = 8'(r); m_c = c; m_v = v; m_z = (r == 0); m_n = r[7];
            m_pend_res = 8'(dr); m_pend_c = dc;
            if (io.decimal_en && io.op < 3'd2) begin m_busy = 1; m_lat = 2; end
            else begin m_load = 1; m_lat = 1; end
         end
      end else if (m_lat == 2) begin
         m_res = m_pend_res; m_c = m_pend_c; m_busy = 0; m_load = 1; m_lat = 1;
      end else begin
         m_load = 0; m_lat = 0;
      end
   end

   initial begin
      logic [7:0] exp_bus;
      forever begin
         @(negedge clk);
         #1;
         exp_bus = bus_enable ? m_res : 8'hFF;
         n_cmp++;
         if ({io.result, io.c_out, io.v_out, io.z_out, io.n_out, io.busy, io.ac_load, data_bus} !==
             {m_res, m_c, m_v, m_z, m_n, m_busy, m_load, exp_bus}) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got res=%h c%b v%b z%b n%b busy%b ld%b bus=%h, want res=%h c%b v%b z%b n%b busy%b ld%b bus=%h",
                     $time, io.result, io.c_out, io.v_out, io.z_out, io.n_out, io.busy, io.ac_load, data_bus,
                     m_res, m_c, m_v, m_z, m_n, m_busy, m_load, exp_bus);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic dec,
                        input logic [2:0] op, output int lat);
      @(negedge clk);
      io.a_in = a; io.b_in = b; io.carry_in = cin; io.decimal_en = dec; io.op = op; io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      lat = 0;
      while (!io.ac_load && lat < 4) begin
         @(negedge clk);
         lat++;
      end
      if (lat == 4) check("ac_load_timeout", 0, 1);
   endtask

   initial begin
      int lat, loads;
      io.a_in = 0; io.b_in = 0; io.carry_in = 0; io.decimal_en = 0; io.op = 0; io.start = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus_enable = 1'b1;
      check("reset_result", int'(io.result), 0);
      check("reset_flags", int'({io.c_out, io.v_out, io.z_out, io.n_out, io.busy, io.ac_load}), 0);

      do_op(8'h50, 8'h50, 0, 0, 3'd0, lat);
      check("adc_bin_lat", lat, 0);
      check("adc_bin_res", int'(io.result), 'hA0);
      check("adc_bin_cvzn", int'({io.c_out, io.v_out, io.z_out, io.n_out}), 'b0101);
      do_op(8'h19, 8'h28, 0, 1, 3'd0, lat);
      check("adc_dec_lat", lat, 1);
      check("adc_dec_res", int'({io.result, io.c_out}), 'h47 << 1);
      do_op(8'h99, 8'h01, 0, 1, 3'd0, lat);
      check("adc_dec_wrap", int'({io.result, io.c_out, io.z_out, io.n_out}), ('h00 << 3) | 'b101);
      do_op(8'h46, 8'h12, 1, 1, 3'd1, lat);
      check("sbc_dec", int'({io.result, io.c_out}), ('h34 << 1) | 1);
      do_op(8'h12, 8'h21, 1, 1, 3'd1, lat);
      check("sbc_dec_borrow", int'({io.result, io.c_out}), 'h91 << 1);
      do_op(8'h81, 8'h00, 0, 0, 3'd5, lat);
      check("lsr", int'({io.result, io.c_out}), ('h40 << 1) | 1);
      do_op(8'h81, 8'h00, 1, 0, 3'd6, lat);
      check("ror", int'({io.result, io.c_out}), ('hC0 << 1) | 1);

      @(negedge clk);
      io.a_in = 8'h19; io.b_in = 8'h28; io.carry_in = 0; io.decimal_en = 1; io.op = 3'd0; io.start = 1'b1;
      loads = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 2) io.start = 1'b0;
         loads += int'(io.ac_load);
      end
      check("hold_start_loads", loads, 1);

      @(negedge clk);
      io.a_in = 8'h19; io.b_in = 8'h28; io.decimal_en = 1; io.op = 3'd0; io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      check("adjust_busy", int'(io.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_adjust_state", int'({io.result, io.c_out, io.v_out, io.z_out, io.n_out, io.busy, io.ac_load}), 0);
      @(negedge clk);
      check("rst_adjust_noload", int'(io.ac_load), 0);

      do_op(8'h3C, 8'h00, 0, 0, 3'd7, lat);
      #2 bus_enable = 1'b0;
      #1 check("bus_off", int'(data_bus), 'hFF);
      bus_enable = 1'b1;
      #1 check("bus_on", int'(data_bus), 'h3C);

      repeat (600) begin
         @(negedge clk);
         io.a_in = 8'($urandom); io.b_in = 8'($urandom); io.carry_in = 1'($urandom);
         io.decimal_en = 1'($urandom); io.op = 3'($urandom); io.start = 1'($urandom);
         bus_enable = 1'($urandom);
         rst = ($urandom % 50) == 0;
      end
      @(negedge clk);
      rst = 1'b0; io.start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
